// File: rtl/switch_conditioner.sv
// switch_conditioner: synchronizes and debounces 8 switch inputs, emitting registered
// clean levels plus per-bit rise/fall pulses and a combined change flag.
module switch_conditioner #(
    parameter int STABLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sw_raw,
    output logic [7:0] sw_clean,
    output logic [7:0] sw_rise,
    output logic [7:0] sw_fall,
    output logic       sw_changed
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
    logic [7:0]    r_sync [SYNC_STAGES];
    logic [CW-1:0] r_cnt [8];
    logic [7:0]    r_clean, r_rise, r_fall;
    logic          r_changed;
    logic [7:0]    w_sync, w_diff, w_done;
    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_diff = w_sync ^ r_clean;
    // A bit is accepted on the edge where its disagreement has lasted STABLE_CYCLES samples.
    always_comb begin
        for (int i = 0; i < 8; i++) w_done[i] = w_diff[i] && (r_cnt[i] == LAST);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
            for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
            r_clean   <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
        end else begin
            r_sync[0] <= sw_raw;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
            for (int i = 0; i < 8; i++) r_cnt[i] <= (w_diff[i] && !w_done[i]) ? r_cnt[i] + CW'(1) : '0;
            r_clean   <= r_clean ^ w_done;
            r_rise    <= w_done & w_sync;
            r_fall    <= w_done & ~w_sync;
            r_changed <= |w_done;
        end
    end
    assign sw_clean   = r_clean;
    assign sw_rise    = r_rise;
    assign sw_fall    = r_fall;
    assign sw_changed = r_changed;
endmodule

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner: directed and random stimulus checked against a sample-history
// model: a bit flips once its last STABLE_CYCLES synchronized samples all disagree with it.
module tb_switch_conditioner;
    localparam int S = 4;
    localparam int Y = 2;
    localparam int H = S + Y - 1;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sw_raw = 8'h00;
    logic [7:0] sw_clean, sw_rise, sw_fall;
    logic       sw_changed;
    int         n_assert = 0;
    int         n_fail = 0;
    logic [7:0] hist [H];
    logic [7:0] m_clean = 8'h00, m_rise = 8'h00, m_fall = 8'h00;
    logic       m_chg = 1'b0;
    logic [7:0] rnd = 8'h00;

    switch_conditioner #(.STABLE_CYCLES(S), .SYNC_STAGES(Y)) dut (
        .clk(clk), .reset(reset), .sw_raw(sw_raw), .sw_clean(sw_clean),
        .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_changed(sw_changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] raw, input logic rst);
        logic [7:0] done;
        logic       v, all;
        sw_raw = raw;
        reset  = rst;
        @(posedge clk);
        if (rst) begin
            for (int j = 0; j < H; j++) hist[j] = 8'h00;
            m_clean = 8'h00; m_rise = 8'h00; m_fall = 8'h00; m_chg = 1'b0;
        end else begin
            for (int b = 0; b < 8; b++) begin
                v   = hist[Y-1][b];
                all = 1'b1;
                for (int j = Y - 1; j <= Y + S - 2; j++) if (hist[j][b] !== v) all = 1'b0;
                done[b] = all && (v !== m_clean[b]);
            end
            m_rise  = done & ~m_clean;
            m_fall  = done & m_clean;
            m_chg   = |done;
            m_clean = m_clean ^ done;
            for (int j = H - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = raw;
        end
        #1;
        check("clean", sw_clean, m_clean);
        check("rise", sw_rise, m_rise);
        check("fall", sw_fall, m_fall);
        check("changed", {7'd0, sw_changed}, {7'd0, m_chg});
        check("rise_fall_overlap", sw_rise & sw_fall, 8'h00);
    endtask

    initial begin
        for (int j = 0; j < H; j++) hist[j] = 8'h00;
        // Reset, then idle low
        repeat (3) step(8'h00, 1'b1);
        repeat (10) step(8'h00, 1'b0);
        check("idle_clean", sw_clean, 8'h00);
        // Single bit rise: accepted on the 6th edge
        repeat (5) step(8'h01, 1'b0);
        check("r027_before", sw_clean, 8'h00);
        step(8'h01, 1'b0);
        check("r027_clean", sw_clean, 8'h01);
        check("r027_rise", sw_rise, 8'h01);
        check("r027_chg", {7'd0, sw_changed}, 8'h01);
        step(8'h01, 1'b0);
        check("r027_rise_after", sw_rise, 8'h00);
        repeat (8) step(8'h00, 1'b0);
        // Short glitch is rejected
        repeat (3) step(8'h08, 1'b0);
        repeat (20) step(8'h00, 1'b0);
        check("r028_clean", sw_clean, 8'h00);
        // All bits rise then fall together
        repeat (8) step(8'hFF, 1'b0);
        check("r029_high", sw_clean, 8'hFF);
        repeat (6) step(8'h00, 1'b0);
        check("r029_fall", sw_fall, 8'hFF);
        check("r029_chg", {7'd0, sw_changed}, 8'h01);
        step(8'h00, 1'b0);
        check("r029_fall_after", sw_fall, 8'h00);
        repeat (4) step(8'h00, 1'b0);
        // Bounce restarts qualification
        step(8'h02, 1'b0); step(8'h00, 1'b0); step(8'h02, 1'b0); step(8'h00, 1'b0);
        repeat (5) step(8'h02, 1'b0);
        check("r030_wait", sw_clean, 8'h00);
        step(8'h02, 1'b0);
        check("r030_rise", sw_rise, 8'h02);
        repeat (4) step(8'h02, 1'b0);
        repeat (8) step(8'h00, 1'b0);
        // Reset mid-level discards state and requalifies
        repeat (8) step(8'h0F, 1'b0);
        check("r031_high", sw_clean, 8'h0F);
        step(8'h0F, 1'b1);
        check("r031_reset", sw_clean, 8'h00);
        repeat (5) step(8'h0F, 1'b0);
        check("r031_wait", sw_rise, 8'h00);
        step(8'h0F, 1'b0);
        check("r031_rise", sw_rise, 8'h0F);
        // Pulses stay low while reset is held regardless of input
        for (int n = 0; n < 8; n++) step(8'($urandom), 1'b1);
        // Random bouncing switches with occasional reset
        rnd = 8'h00;
        for (int n = 0; n < 800; n++) begin
            for (int b = 0; b < 8; b++) if ($urandom_range(0, 5) == 0) rnd[b] = ~rnd[b];
            step(rnd, $urandom_range(0, 99) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/switch_conditioner.md
SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 Parameter: STABLE_CYCLES, default 16; consecutive cycles a synchronized bit must hold a new level before it is accepted; legal range 2..65535.
REQ-002 Parameter: SYNC_STAGES, default 2; flip-flop stages per bit in the input synchronizer; legal range 2..4.
REQ-003 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  reset, synchronous, active-high.
REQ-005 Port: sw_raw  input  8  asynchronous switch levels from the board pins.
REQ-006 Port: sw_clean  output  8  debounced switch levels, registered; drives the design's ui_in.
REQ-007 Port: sw_rise  output  8  per-bit one-cycle pulse, high in the cycle sw_clean[i] goes 0->1.
REQ-008 Port: sw_fall  output  8  per-bit one-cycle pulse, high in the cycle sw_clean[i] goes 1->0.
REQ-009 Port: sw_changed  output  1  registered OR of all sw_rise and sw_fall bits, same cycle as those pulses.

Function
REQ-010 Each bit shall pass through its own SYNC_STAGES-deep flop chain; sw_sync[i] is the last stage; no combinational path from sw_raw to any output.
REQ-011 Each bit shall own an independent counter cnt[i] of width clog2(STABLE_CYCLES); the 8 bits shall not interact.
REQ-012 When sw_sync[i] == sw_clean[i], cnt[i] shall load 0 on the next edge.
REQ-013 When sw_sync[i] != sw_clean[i] and cnt[i] < STABLE_CYCLES-1, cnt[i] shall increment by 1.
REQ-014 When sw_sync[i] != sw_clean[i] and cnt[i] == STABLE_CYCLES-1, on that edge sw_clean[i] shall take sw_sync[i], cnt[i] shall load 0, and sw_rise[i] or sw_fall[i] shall be set per direction.
REQ-015 cnt[i] shall never exceed STABLE_CYCLES-1 and shall never wrap.
REQ-016 Latency: a level held on sw_raw[i] from rising edge E1 onward shall appear on sw_clean[i] at edge number SYNC_STAGES+STABLE_CYCLES, counting E1 as edge 1; defaults give edge 18.
REQ-017 Glitch rejection: any sw_raw[i] excursion whose synchronized width is < STABLE_CYCLES cycles shall leave sw_clean[i], sw_rise[i] and sw_fall[i] unchanged.
REQ-018 Bounce: any return of sw_sync[i] to the sw_clean[i] level shall restart qualification from cnt[i]=0.
REQ-019 sw_rise[i] and sw_fall[i] shall be registered, high for exactly one cycle per accepted transition, and never high together.
REQ-020 Simultaneous acceptance on several bits in one cycle shall assert all their pulse bits in that cycle, with a single-cycle sw_changed.
REQ-021 A new transition on bit i may be accepted no sooner than STABLE_CYCLES cycles after the previous one; pulses on the same bit shall never be back-to-back.

Reset
REQ-022 With reset high at a rising edge, all sync flops, sw_clean, cnt[], sw_rise, sw_fall and sw_changed shall become 0 on that edge.
REQ-023 Reset asserted mid-qualification shall discard the partial count; after release, a sw_raw bit held at 1 shall yield sw_rise after the full REQ-016 latency.
REQ-024 While reset is high, sw_rise, sw_fall and sw_changed shall stay 0 whatever sw_raw does.
REQ-025 Without reset, no output shall be depended on; the bench shall apply reset before checking.

Verification (STABLE_CYCLES=4, SYNC_STAGES=2)
REQ-026 Reset 3 cycles with sw_raw=8'h00, then hold 10 cycles -> sw_clean=8'h00; sw_rise, sw_fall, sw_changed all 0 throughout.
REQ-027 sw_raw 8'h00->8'h01 at edge E1, held -> sw_clean=8'h01 from edge E6; sw_rise=8'h01 and sw_changed=1 for exactly the E6 cycle; 0 before and after.
REQ-028 sw_raw[3] high for 3 cycles, then low -> sw_clean, sw_rise, sw_fall remain 8'h00 for 20 cycles.
REQ-029 sw_raw=8'hFF until sw_clean=8'hFF, then 8'h00 -> sw_fall=8'hFF for one cycle, 6 edges after the change; sw_changed one cycle; sw_rise 0.
REQ-030 sw_raw[1] pattern 1,0,1,0,1 (one cycle each) then held 1 -> sw_clean[1] rises 6 edges after the final 0->1; exactly one sw_rise[1] pulse.
REQ-031 sw_raw=8'h0F held and sw_clean=8'h0F; reset for 1 cycle -> sw_clean=8'h00 next edge; after release, sw_rise=8'h0F for one cycle at edge 6.
